mux_packer: RTL and testbench

MUX_PACKER -- requirements
Module: mux_packer

---
 rtl/mux_packer.sv | 100 ++++++++++
 tb/tb_mux_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_packer.sv
// mux_packer
// Selects one of three byte channels and packs accepted bytes MSB-first
// into a 4-byte word held in a single-entry output register.
//
// Ports:
//   clk_sys            single clock, rising edge
//   rst                synchronous active-high reset
//   select[1:0]        source channel: 00=ch0, 01=ch1, 10=ch2, 11=none
//   dataN_i/validN_i   channel N byte and its qualifier (N = 0..2)
//   ready_o            a byte can be accepted this cycle (combinational)
//   data_o             packed word (held when valid_o=0)
//   valid_o            data_o holds an unconsumed word
//   ready_i            downstream consumes data_o when valid_o=1
//   drop_o             one-cycle pulse after a partial word is discarded
//
// MST_DWIDTH must equal 4*SYS_DWIDTH.
module mux_packer #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [1:0]            select,
    input  logic [SYS_DWIDTH-1:0] data0_i,
    input  logic                  valid0_i,
    input  logic [SYS_DWIDTH-1:0] data1_i,
    input  logic                  valid1_i,
    input  logic [SYS_DWIDTH-1:0] data2_i,
    input  logic                  valid2_i,
    output logic                  ready_o,
    output logic [MST_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  drop_o
);

    logic [1:0]            count;
    logic [1:0]            sel_q;
    logic [MST_DWIDTH-1:0] asm_q;

    logic [SYS_DWIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  drop_now;
    logic [1:0]            eff_count;
    logic                  accept;
    logic                  load;
    logic [MST_DWIDTH-1:0] asm_next;

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        case (select)
            2'b00: begin sel_data = data0_i; sel_valid = valid0_i; end
            2'b01: begin sel_data = data1_i; sel_valid = valid1_i; end
            2'b10: begin sel_data = data2_i; sel_valid = valid2_i; end
            default: begin sel_data = '0; sel_valid = 1'b0; end
        endcase
    end

    // Only the 4th byte needs room in the output register, so stall it alone.
    assign ready_o = !((count == 2'd3) && valid_o && !ready_i);

    // A select change with a partial word pending discards it; a byte from the
    // new channel on this same edge then becomes byte 1 of a fresh word.
    assign drop_now  = (select != sel_q) && (count != 2'd0);
    assign eff_count = drop_now ? 2'd0 : count;
    assign accept    = sel_valid && ready_o;
    assign load      = accept && (eff_count == 2'd3);

    always_comb begin
        asm_next = drop_now ? '0 : asm_q;
        for (int i = 0; i < 4; i++) begin
            if (accept && (eff_count == 2'(i)))
                asm_next[(3-i)*SYS_DWIDTH +: SYS_DWIDTH] = sel_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            count   <= 2'd0;
            sel_q   <= 2'b00;
            asm_q   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            drop_o  <= 1'b0;
        end else begin
            sel_q  <= select;
            drop_o <= drop_now;
            // 2-bit counter wraps 3->0 naturally on the 4th accept
            count  <= accept ? eff_count + 2'd1 : eff_count;
            asm_q  <= load ? '0 : asm_next;
            if (load)
                data_o <= asm_next;
            // A load can only coincide with a full register when it is being
            // consumed on the same edge, so nothing is ever overwritten.
            valid_o <= load || (valid_o && !ready_i);
        end
    end

endmodule

// File: tb/tb_mux_packer.sv
// Testbench for mux_packer: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based model.
module tb_mux_packer;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [1:0]  select;
    logic [7:0]  data0_i, data1_i, data2_i;
    logic        valid0_i, valid1_i, valid2_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        drop_o;

    mux_packer #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .select  (select),
        .data0_i (data0_i),
        .valid0_i(valid0_i),
        .data1_i (data1_i),
        .valid1_i(valid1_i),
        .data2_i (data2_i),
        .valid2_i(valid2_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .drop_o  (drop_o)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests  = 0;
    int n_fail   = 0;
    int drop_cnt = 0;
    bit chk_en   = 0;

    // Behavioural model: bytes of the word in progress kept in a queue.
    logic [7:0]  m_q[$];
    logic [1:0]  m_sel   = 2'b00;
    logic        m_valid = 1'b0;
    logic        m_drop  = 1'b0;
    logic [31:0] m_data  = 32'h0;

    always @(posedge clk_sys) begin
        logic [7:0] b;
        logic       v, rdy, cons, dropnow, ld;
        if (rst) begin
            m_q.delete();
            m_sel = 2'b00; m_valid = 1'b0; m_drop = 1'b0; m_data = 32'h0;
        end else begin
            case (select)
                2'b00:   begin v = valid0_i; b = data0_i; end
                2'b01:   begin v = valid1_i; b = data1_i; end
                2'b10:   begin v = valid2_i; b = data2_i; end
                default: begin v = 1'b0;     b = 8'h00;   end
            endcase
            rdy     = !(m_q.size() == 3 && m_valid && !ready_i);
            cons    = m_valid && ready_i;
            dropnow = (select != m_sel) && (m_q.size() != 0);
            if (dropnow) m_q.delete();
            ld = 1'b0;
            if (v && rdy) begin
                m_q.push_back(b);
                if (m_q.size() == 4) begin
                    m_data = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    ld = 1'b1;
                    m_q.delete();
                end
            end
            m_valid = ld || (m_valid && !cons);
            m_drop  = dropnow;
            m_sel   = select;
        end
    end

    always @(negedge clk_sys) begin
        logic exp_rdy;
        if (chk_en) begin
            exp_rdy = !(m_q.size() == 3 && m_valid && !ready_i);
            n_tests++;
            if (ready_o !== exp_rdy || valid_o !== m_valid ||
                data_o !== m_data || drop_o !== m_drop) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: dut rdy/vld/drop/data=%b/%b/%b/%h model=%b/%b/%b/%h",
                         $time, ready_o, valid_o, drop_o, data_o,
                         exp_rdy, m_valid, m_drop, m_data);
            end
            if (drop_o === 1'b1) drop_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_valids();
        valid0_i = 1'b0; valid1_i = 1'b0; valid2_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    // Present byte b on channel ch until it is accepted (bounded wait).
    task automatic send(input int ch, input logic [7:0] b, input bit junk = 1'b0);
        int   w;
        logic r;
        if (junk) begin
            valid0_i = 1'($urandom); data0_i = 8'($urandom);
            valid1_i = 1'($urandom); data1_i = 8'($urandom);
            valid2_i = 1'($urandom); data2_i = 8'($urandom);
        end
        case (ch)
            0: begin data0_i = b; valid0_i = 1'b1; end
            1: begin data1_i = b; valid1_i = 1'b1; end
            default: begin data2_i = b; valid2_i = 1'b1; end
        endcase
        w = 0;
        do begin
            #1 r = ready_o;
            tick();
            w++;
        end while (!r && w < 50);
        if (!r) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte %h on ch%0d not accepted after %0d cycles", b, ch, w);
        end
        clr_valids();
    endtask

    task automatic idle(input int n);
        clr_valids();
        repeat (n) tick();
    endtask

    initial begin
        int   d0, vcnt;
        logic rdy_ok;
        rst = 1'b1; select = 2'b00; ready_i = 1'b1;
        data0_i = 8'h0; data1_i = 8'h0; data2_i = 8'h0;
        clr_valids();
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;
        #1;
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_data",  data_o,       32'h0);
        chk("reset_drop",  32'(drop_o),  32'd0);
        chk("reset_ready", 32'(ready_o), 32'd1);

        // Basic pack on ch0
        select = 2'b00;
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
        chk("basic_valid", 32'(valid_o), 32'd1);
        chk("basic_data",  data_o,       32'h11223344);
        idle(1);
        chk("basic_consumed", 32'(valid_o), 32'd0);
        chk("basic_hold",     data_o,       32'h11223344);

        // Backpressure on ch1
        select = 2'b01; ready_i = 1'b0;
        for (int i = 0; i < 7; i++) send(1, 8'hAA + 8'(i));
        data1_i = 8'hB1; valid1_i = 1'b1;
        #1 chk("bp_ready_low", 32'(ready_o), 32'd0);
        tick(); tick(); tick();
        chk("bp_data_held",  data_o,       32'hAAABACAD);
        chk("bp_valid_held", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        #1 chk("bp_ready_release", 32'(ready_o), 32'd1);
        tick();
        clr_valids();
        chk("bp_second_word",  data_o,       32'hAEAFB0B1);
        chk("bp_second_valid", 32'(valid_o), 32'd1);
        idle(1);

        // Channel isolation on ch2 with junk elsewhere
        select = 2'b10;
        send(2, 8'h01, 1'b1); send(2, 8'h02, 1'b1);
        send(2, 8'h03, 1'b1); send(2, 8'h04, 1'b1);
        chk("iso_data", data_o, 32'h01020304);
        idle(1);

        // Select change mid-word
        select = 2'b00;
        send(0, 8'h61); send(0, 8'h62);
        d0 = drop_cnt;
        select = 2'b01;
        send(1, 8'h55);
        chk("selchg_drop_pulse", 32'(drop_o), 32'd1);
        send(1, 8'h56);
        chk("selchg_drop_end", 32'(drop_o), 32'd0);
        send(1, 8'h57); send(1, 8'h58);
        chk("selchg_data", data_o, 32'h55565758);
        chk("selchg_drop_count", 32'(drop_cnt - d0), 32'd1);
        idle(1);

        // Reset mid-word
        select = 2'b00;
        d0 = drop_cnt;
        send(0, 8'h71); send(0, 8'h72); send(0, 8'h73);
        rst = 1'b1; data0_i = 8'hEE; valid0_i = 1'b1;
        tick();
        rst = 1'b0; clr_valids();
        chk("rst_mid_valid", 32'(valid_o), 32'd0);
        chk("rst_mid_data",  data_o,       32'h0);
        send(0, 8'h09); send(0, 8'h0A); send(0, 8'h0B); send(0, 8'h0C);
        chk("rst_mid_word", data_o, 32'h090A0B0C);
        idle(1);
        chk("rst_mid_no_drop", 32'(drop_cnt - d0), 32'd0);

        // Back-to-back 12 bytes
        ready_i = 1'b1; rdy_ok = 1'b1; vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            data0_i = 8'h21 + 8'(i); valid0_i = 1'b1;
            #1 if (!ready_o) rdy_ok = 1'b0;
            tick();
            if (valid_o) vcnt++;
        end
        clr_valids();
        chk("b2b_ready_const", 32'(rdy_ok), 32'd1);
        chk("b2b_word_count",  32'(vcnt),   32'd3);
        chk("b2b_last_word",   data_o,      32'h292A2B2C);
        idle(2);

        // Randomized phase against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) select = 2'($urandom);
            valid0_i = 1'($urandom); data0_i = 8'($urandom);
            valid1_i = 1'($urandom); data1_i = 8'($urandom);
            valid2_i = 1'($urandom); data2_i = 8'($urandom);
            ready_i  = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
